// File: rtl/banco_pkg.sv
// Shared types and helpers for the parametrised register bank.
package banco_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Bit offset of port 'port' inside a packed bus of 'width'-bit fields.
  function automatic int rd_slice_off(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/banco_clear_ctrl.sv
// Bulk-clear sequencer: walks every register once, drives busy/clr_done,
// and flags user writes that arrive while the clear owns the array.
module banco_clear_ctrl
  import banco_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk1,
  input  logic              rst1,
  input  logic              clr_start,
  input  logic              wr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_drop,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // Counter carries one spare bit so the terminal compare never sees a wrap.
  localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  clr_state_t      state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = wr_req && busy_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign busy     = busy_q;
  assign clr_done = done_q;
  assign wr_drop  = drop_q;
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/banco_registro_param.sv
// Multi-port register bank with combinational reads, optional write bypass,
// optional hardwired zero register and a sequenced bulk clear.
module banco_registro_param
  import banco_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk1,
  input  logic                     rst1,
  input  logic [NUM_RD*ADDR_W-1:0] addr_rd,
  output logic [NUM_RD*DATA_W-1:0] dat_rd,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        addr_w,
  input  logic [DATA_W-1:0]        dat_w,
  input  logic                     clr_start,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_req;
  logic              wr_ok;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  // Writes to a hardwired zero register vanish silently, so they never count as dropped.
  assign wr_req = reg_write && !((ZERO_REG != 0) && (addr_w == '0));
  assign wr_ok  = wr_req && !busy;

  banco_clear_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_clear_ctrl (
    .clk1     (clk1),
    .rst1     (rst1),
    .clr_start(clr_start),
    .wr_req   (wr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[addr_w] = dat_w;
    if (clr_we) mem_d[clr_addr] = '0;
  end

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) mem_q <= '{default: '0};
    else      mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    localparam int A_OFF = rd_slice_off(i, ADDR_W);
    localparam int D_OFF = rd_slice_off(i, DATA_W);

    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;

    assign raddr = addr_rd[A_OFF +: ADDR_W];

    // Zero masking is applied last so it also overrides the bypass path.
    always_comb begin
      rdata = mem_q[raddr];
      if ((BYPASS != 0) && wr_ok && (addr_w == raddr)) rdata = dat_w;
      if ((ZERO_REG != 0) && (raddr == '0)) rdata = '0;
    end

    assign dat_rd[D_OFF +: DATA_W] = rdata;
  end

endmodule

// File: tb/tb_banco_registro_param.sv
// Bench for banco_registro_param: three parameter variants share one stimulus
// stream and are compared each cycle against a behavioural model.
module tb_banco_registro_param;

  logic       clk1 = 1'b0;
  logic       rst1;
  logic [5:0] addr_rd;
  logic       reg_write;
  logic [2:0] addr_w;
  logic [3:0] dat_w;
  logic       clr_start;

  logic [7:0] dat_rd_a [3];
  logic       busy_a   [3];
  logic       done_a   [3];
  logic       drop_a   [3];

  int vectors = 0;
  int miscompares = 0;
  string step = "init";

  int  mm [3][8];
  bit  mbusy;
  int  midx;
  bit  mdone;
  bit  mdrop [3];

  always #5 clk1 = ~clk1;

  banco_registro_param #(.DATA_W(4), .ADDR_W(3), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)) u_def (
    .clk1(clk1), .rst1(rst1), .addr_rd(addr_rd), .dat_rd(dat_rd_a[0]),
    .reg_write(reg_write), .addr_w(addr_w), .dat_w(dat_w), .clr_start(clr_start),
    .busy(busy_a[0]), .clr_done(done_a[0]), .wr_drop(drop_a[0]));

  banco_registro_param #(.DATA_W(4), .ADDR_W(3), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)) u_nbp (
    .clk1(clk1), .rst1(rst1), .addr_rd(addr_rd), .dat_rd(dat_rd_a[1]),
    .reg_write(reg_write), .addr_w(addr_w), .dat_w(dat_w), .clr_start(clr_start),
    .busy(busy_a[1]), .clr_done(done_a[1]), .wr_drop(drop_a[1]));

  banco_registro_param #(.DATA_W(4), .ADDR_W(3), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) u_zr (
    .clk1(clk1), .rst1(rst1), .addr_rd(addr_rd), .dat_rd(dat_rd_a[2]),
    .reg_write(reg_write), .addr_w(addr_w), .dat_w(dat_w), .clr_start(clr_start),
    .busy(busy_a[2]), .clr_done(done_a[2]), .wr_drop(drop_a[2]));

  function automatic bit byp(input int d);
    return d != 1;
  endfunction

  function automatic bit zr(input int d);
    return d == 2;
  endfunction

  function automatic logic [7:0] exp_rd(input int d, input int a);
    if (zr(d) && a == 0) return 8'd0;
    if (byp(d) && reg_write && !mbusy && a == int'(addr_w)) return {4'd0, dat_w};
    return 8'(mm[d][a]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 8; a++) mm[d][a] = 0;
      mdrop[d] = 0;
    end
    mbusy = 0;
    midx  = 0;
    mdone = 0;
  endtask

  task automatic model_edge();
    bit was_busy;
    was_busy = mbusy;
    for (int d = 0; d < 3; d++) begin
      bit to_zero;
      to_zero  = zr(d) && addr_w == 3'd0;
      mdrop[d] = reg_write && was_busy && !to_zero;
      if (reg_write && !was_busy && !to_zero) mm[d][addr_w] = int'(dat_w);
    end
    if (was_busy) begin
      for (int d = 0; d < 3; d++) mm[d][midx] = 0;
      midx  = midx + 1;
      mdone = (midx == 8);
      if (midx == 8) mbusy = 0;
    end else begin
      mdone = 0;
      if (clr_start) begin
        mbusy = 1;
        midx  = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++)
        chk($sformatf("u%0d_rd%0d", d, p), {4'd0, dat_rd_a[d][p*4 +: 4]},
            exp_rd(d, int'(addr_rd[p*3 +: 3])));
      chk($sformatf("u%0d_busy", d), {7'd0, busy_a[d]}, {7'd0, mbusy});
      chk($sformatf("u%0d_done", d), {7'd0, done_a[d]}, {7'd0, mdone});
      chk($sformatf("u%0d_drop", d), {7'd0, drop_a[d]}, {7'd0, mdrop[d]});
    end
  endtask

  task automatic drive(input bit we, input int aw, input int dw, input int r0, input int r1,
                       input bit cs);
    reg_write = we;
    addr_w    = 3'(aw);
    dat_w     = 4'(dw);
    addr_rd   = {3'(r1), 3'(r0)};
    clr_start = cs;
  endtask

  task automatic tick();
    #1 check_all();
    @(posedge clk1);
    model_edge();
    @(negedge clk1);
  endtask

  initial begin
    int busy_cnt;
    rst1 = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk1);
    rst1 = 1'b0;

    step = "reset_reads";
    for (int k = 0; k < 8; k++) begin drive(0, 0, 0, k, 7 - k, 0); tick(); end

    step = "fill";
    for (int k = 0; k < 8; k++) begin drive(1, k, k, k, 7 - k, 0); tick(); end
    step = "readback";
    for (int k = 0; k < 8; k++) begin drive(0, 0, 0, k, 7 - k, 0); tick(); end

    step = "bypass";
    drive(1, 5, 4'hA, 5, 4, 0); tick();
    drive(0, 0, 0, 5, 4, 0); tick();

    step = "clear";
    for (int k = 0; k < 8; k++) begin drive(1, k, 4'hF, 2, 6, 0); tick(); end
    drive(0, 0, 0, 2, 6, 1); tick();
    busy_cnt = 0;
    for (int c = 0; c < 11; c++) begin
      drive(0, 0, 0, 2, 6, 0);
      #1 busy_cnt += int'(busy_a[0]);
      #0 tick();
    end
    chk("busy_len", 8'(busy_cnt), 8'd8);
    for (int k = 0; k < 8; k++) begin drive(0, 0, 0, k, 7 - k, 0); tick(); end

    step = "wr_during_clear";
    drive(1, 3, 5, 3, 0, 0); tick();
    drive(0, 0, 0, 3, 0, 1); tick();
    drive(0, 0, 0, 3, 0, 0); tick();
    busy_cnt = 2;
    drive(1, 3, 9, 3, 0, 1); tick();
    for (int c = 0; c < 9; c++) begin
      drive(0, 0, 0, 3, 1, 0);
      #1 busy_cnt += int'(busy_a[0]);
      #0 tick();
    end
    chk("busy_len_norestart", 8'(busy_cnt), 8'd8);

    step = "zero_reg";
    drive(1, 0, 7, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();

    step = "rst_mid_clear";
    for (int k = 0; k < 8; k++) begin drive(1, k, 15 - k, k, 0, 0); tick(); end
    drive(0, 0, 0, 1, 6, 1); tick();
    for (int c = 0; c < 3; c++) begin drive(0, 0, 0, 1, 6, 0); tick(); end
    rst1 = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst1 = 1'b0;
    for (int c = 0; c < 10; c++) begin drive(0, 0, 0, 1, 6, 0); tick(); end
    drive(1, 1, 3, 1, 6, 0); tick();
    drive(0, 0, 0, 1, 6, 0); tick();

    step = "random";
    for (int c = 0; c < 400; c++) begin
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
